// File: rtl/yari_mem_bridge_pkg.sv
// Shared constants for the yari memory bridge: requester tags and default geometry.
package yari_mem_bridge_pkg;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_DC   = 2'd1;
    localparam logic [1:0] ID_IC   = 2'd2;

    localparam int DEF_DEPTH_LOG2 = 3;
    localparam int DEF_ID_W       = 2;
    localparam int DEF_A_W        = 30;

endpackage

// File: rtl/mem_tag_fifo.sv
// Show-ahead tag FIFO remembering which requester owns each outstanding read.
module mem_tag_fifo #(
    parameter int W          = 2,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/yari_mem_bridge.sv
// Bridges the yari core mem_* port to an in-order variable-latency slave, tagging returns.
// Optional MEM_BRIDGE_PERF_EN adds read/write/stall performance counters.
module yari_mem_bridge
    import yari_mem_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int ID_W       = DEF_ID_W,
    parameter int A_W        = DEF_A_W
) (
    input  logic            clock,
    input  logic            rst,
    output logic            mem_waitrequest,
    input  logic [ID_W-1:0] mem_id,
    input  logic [A_W-1:0]  mem_address,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [31:0]     mem_writedata,
    input  logic [3:0]      mem_writedatamask,
    output logic [31:0]     mem_readdata,
    output logic [ID_W-1:0] mem_readdataid,
    input  logic            ext_waitrequest,
    output logic [A_W-1:0]  ext_address,
    output logic            ext_read,
    output logic            ext_write,
    output logic [31:0]     ext_writedata,
    output logic [3:0]      ext_byteenable,
    input  logic [31:0]     ext_readdata,
    input  logic            ext_readdatavalid,
    output logic            err_orphan,
    output logic [31:0]     perf_reads,
    output logic [31:0]     perf_writes,
    output logic [31:0]     perf_stalls
);

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            read_only;
    logic [ID_W-1:0] head_id;

    // A simultaneous read and write is treated as a write; the read is dropped.
    assign read_only       = mem_read & ~mem_write;
    assign ext_address     = mem_address;
    assign ext_writedata   = mem_writedata;
    assign ext_byteenable  = mem_writedatamask;
    assign ext_write       = mem_write;
    assign ext_read        = read_only & ~full;
    assign mem_waitrequest = ext_waitrequest | (read_only & full);

    assign push = ext_read & ~ext_waitrequest;
    assign pop  = ext_readdatavalid & ~empty;

    mem_tag_fifo #(
        .W          (ID_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tag_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (mem_id),
        .dout  (head_id),
        .full  (full),
        .empty (empty)
    );

    // Returns are registered; readdata holds its last value when no tag is presented.
    always_ff @(posedge clock) begin
        if (rst) begin
            mem_readdata   <= '0;
            mem_readdataid <= ID_W'(ID_NONE);
            err_orphan     <= 1'b0;
        end else begin
            if (pop) begin
                mem_readdata   <= ext_readdata;
                mem_readdataid <= head_id;
            end else begin
                mem_readdataid <= ID_W'(ID_NONE);
            end
            if (ext_readdatavalid & empty) err_orphan <= 1'b1;
        end
    end

`ifdef MEM_BRIDGE_PERF_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (push)                                  perf_reads  <= perf_reads + 32'd1;
            if (mem_write & ~ext_waitrequest)          perf_writes <= perf_writes + 32'd1;
            if ((mem_read | mem_write) & mem_waitrequest) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_reads  = 32'd0;
    assign perf_writes = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_yari_mem_bridge.sv
// Directed self-checking bench for yari_mem_bridge.
module tb_yari_mem_bridge;

`ifdef MEM_BRIDGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;
    logic        ext_waitrequest;
    logic [29:0] ext_address;
    logic        ext_read;
    logic        ext_write;
    logic [31:0] ext_writedata;
    logic [3:0]  ext_byteenable;
    logic [31:0] ext_readdata;
    logic        ext_readdatavalid;
    logic        err_orphan;
    logic [31:0] perf_reads;
    logic [31:0] perf_writes;
    logic [31:0] perf_stalls;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clock = ~clock;

    yari_mem_bridge dut (
        .clock             (clock),
        .rst               (rst),
        .mem_waitrequest   (mem_waitrequest),
        .mem_id            (mem_id),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_writedatamask (mem_writedatamask),
        .mem_readdata      (mem_readdata),
        .mem_readdataid    (mem_readdataid),
        .ext_waitrequest   (ext_waitrequest),
        .ext_address       (ext_address),
        .ext_read          (ext_read),
        .ext_write         (ext_write),
        .ext_writedata     (ext_writedata),
        .ext_byteenable    (ext_byteenable),
        .ext_readdata      (ext_readdata),
        .ext_readdatavalid (ext_readdatavalid),
        .err_orphan        (err_orphan),
        .perf_reads        (perf_reads),
        .perf_writes       (perf_writes),
        .perf_stalls       (perf_stalls)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] id,
                                 input logic [29:0] addr);
        mem_read    = rd;
        mem_write   = wr;
        mem_id      = id;
        mem_address = addr;
    endtask

    task automatic checkPerf(input string tag, input int reads, input int writes, input int stalls);
        checkOutput({tag, "_reads"},  perf_reads,  PERF ? 32'(reads)  : 32'd0);
        checkOutput({tag, "_writes"}, perf_writes, PERF ? 32'(writes) : 32'd0);
        checkOutput({tag, "_stalls"}, perf_stalls, PERF ? 32'(stalls) : 32'd0);
    endtask

    logic [1:0]  drain_ids [8];
    logic [31:0] burst_data [3];
    logic [1:0]  burst_ids [3];

    initial begin
        rst               = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 30'd0);
        mem_writedata     = 32'd0;
        mem_writedatamask = 4'd0;
        ext_waitrequest   = 1'b0;
        ext_readdata      = 32'd0;
        ext_readdatavalid = 1'b0;
        drain_ids  = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
        burst_data = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        burst_ids  = '{2'd2, 2'd1, 2'd2};
        tick;
        tick;
        rst = 1'b0;
        #1;
        checkOutput("rst_id",   mem_readdataid, 32'd0);
        checkOutput("rst_data", mem_readdata, 32'd0);
        checkOutput("rst_err",  err_orphan, 32'd0);
        checkOutput("rst_wait", mem_waitrequest, 32'd0);
        checkPerf("rst", 0, 0, 0);

        // Single read, returned three cycles later
        applyStimulus(1'b1, 1'b0, 2'd1, 30'h100);
        #1;
        checkOutput("rd1_ext_read", ext_read, 32'd1);
        checkOutput("rd1_addr", ext_address, 32'h100);
        checkOutput("rd1_wait", mem_waitrequest, 32'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 2'd0, 30'd0);
        tick;
        tick;
        ext_readdatavalid = 1'b1;
        ext_readdata      = 32'hDEADBEEF;
        #1;
        checkOutput("rd1_pre_id", mem_readdataid, 32'd0);
        tick;
        ext_readdatavalid = 1'b0;
        ext_readdata      = 32'h0;
        checkOutput("rd1_id", mem_readdataid, 32'd1);
        checkOutput("rd1_data", mem_readdata, 32'hDEADBEEF);
        tick;
        checkOutput("rd1_idle_id", mem_readdataid, 32'd0);
        checkOutput("rd1_hold_data", mem_readdata, 32'hDEADBEEF);
        checkPerf("rd1", 1, 0, 0);

        // Three back-to-back reads with consecutive in-order returns
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, burst_ids[i], 30'h200 + 30'(i));
            tick;
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 30'd0);
        for (int i = 0; i < 3; i++) begin
            ext_readdatavalid = 1'b1;
            ext_readdata      = burst_data[i];
            tick;
            checkOutput("burst_id", mem_readdataid, 32'(burst_ids[i]));
            checkOutput("burst_data", mem_readdata, burst_data[i]);
        end
        ext_readdatavalid = 1'b0;
        tick;
        checkOutput("burst_end_id", mem_readdataid, 32'd0);

        // Fill all eight tags, then a ninth read must stall until one returns
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 2'd1 : 2'd2, 30'h300 + 30'(i));
            tick;
        end
        applyStimulus(1'b1, 1'b0, 2'd2, 30'h3FF);
        #1;
        checkOutput("full_wait", mem_waitrequest, 32'd1);
        checkOutput("full_ext_read", ext_read, 32'd0);
        tick;
        ext_readdatavalid = 1'b1;
        ext_readdata      = 32'h00001000;
        #1;
        checkOutput("full_pop_wait", mem_waitrequest, 32'd1);
        tick;
        ext_readdatavalid = 1'b0;
        checkOutput("full_pop_id", mem_readdataid, 32'd1);
        checkOutput("full_pop_data", mem_readdata, 32'h00001000);
        checkOutput("ninth_wait", mem_waitrequest, 32'd0);
        checkOutput("ninth_ext_read", ext_read, 32'd1);
        tick;
        applyStimulus(1'b0, 1'b0, 2'd0, 30'd0);
        for (int k = 0; k < 8; k++) begin
            ext_readdatavalid = 1'b1;
            ext_readdata      = 32'h2000 + 32'(k);
            tick;
            checkOutput("drain_id", mem_readdataid, 32'(drain_ids[k]));
        end
        ext_readdatavalid = 1'b0;
        tick;
        checkOutput("drain_end_id", mem_readdataid, 32'd0);
        checkOutput("drain_err", err_orphan, 32'd0);
        checkPerf("full", 13, 0, 2);

        // Write held under slave stall for two cycles
        mem_write         = 1'b1;
        mem_address       = 30'h0ABC;
        mem_writedata     = 32'h12345678;
        mem_writedatamask = 4'b0011;
        ext_waitrequest   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("wr_wait", mem_waitrequest, 32'd1);
            checkOutput("wr_ext_write", ext_write, 32'd1);
            checkOutput("wr_ext_read", ext_read, 32'd0);
            checkOutput("wr_data", ext_writedata, 32'h12345678);
            checkOutput("wr_be", ext_byteenable, 32'h3);
            tick;
        end
        ext_waitrequest = 1'b0;
        #1;
        checkOutput("wr_accept_wait", mem_waitrequest, 32'd0);
        tick;
        checkOutput("wr_id", mem_readdataid, 32'd0);
        applyStimulus(1'b1, 1'b1, 2'd1, 30'h0DEF);
        #1;
        checkOutput("rw_ext_read", ext_read, 32'd0);
        checkOutput("rw_ext_write", ext_write, 32'd1);
        tick;
        applyStimulus(1'b0, 1'b0, 2'd0, 30'd0);
        mem_writedatamask = 4'd0;
        tick;
        checkPerf("wr", 13, 2, 4);

        // Return with nothing outstanding is an orphan
        ext_readdatavalid = 1'b1;
        ext_readdata      = 32'h55555555;
        tick;
        ext_readdatavalid = 1'b0;
        checkOutput("orphan_id", mem_readdataid, 32'd0);
        checkOutput("orphan_err", err_orphan, 32'd1);
        checkOutput("orphan_data_hold", mem_readdata, 32'h00002007);
        tick;
        tick;
        checkOutput("orphan_sticky", err_orphan, 32'd1);

        // Reset with four reads pending; their late returns become orphans
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd1, 30'h400 + 30'(i));
            tick;
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 30'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("rst2_err", err_orphan, 32'd0);
        checkOutput("rst2_id", mem_readdataid, 32'd0);
        checkOutput("rst2_data", mem_readdata, 32'd0);
        checkPerf("rst2", 0, 0, 0);
        mem_read = 1'b1;
        #1;
        checkOutput("rst2_ext_read", ext_read, 32'd1);
        mem_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ext_readdatavalid = 1'b1;
            ext_readdata      = 32'h7000 + 32'(k);
            tick;
            checkOutput("late_id", mem_readdataid, 32'd0);
        end
        ext_readdatavalid = 1'b0;
        tick;
        checkOutput("late_err", err_orphan, 32'd1);
        checkOutput("late_data", mem_readdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
